// File: rtl/key_conditioner_if.sv
// Key signals between the board pins (master side drives key_raw) and the conditioner.
// Handshake: none. key_raw is a free-running asynchronous level. All outputs are registered levels or 1-cycle strobes in the clk domain.
interface key_conditioner_if #(
  parameter int KEY_N = 4
);
  logic [KEY_N-1:0] key_raw;
  logic [KEY_N-1:0] keys;
  logic [KEY_N-1:0] key_press;
  logic [KEY_N-1:0] key_release;
  logic [KEY_N-1:0] key_repeat;

  modport master (
    output key_raw,
    input  keys, key_press, key_release, key_repeat
  );

  modport slave (
    input  key_raw,
    output keys, key_press, key_release, key_repeat
  );
endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key synchroniser, debounce, active-high level,
// press/release pulses and optional auto-repeat strobes.
module key_conditioner #(
  parameter int KEY_N          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int DB_CYCLES      = 500_000,
  parameter int REPEAT_EN      = 1,
  parameter int REPEAT_DELAY   = 25_000_000,
  parameter int REPEAT_PERIOD  = 5_000_000
) (
  input  logic             clk,
  input  logic             resetn,
  key_conditioner_if.slave kif
);

  localparam logic             ACT_LOW = (KEY_ACTIVE_LOW != 0);
  localparam logic [KEY_N-1:0] INACT   = {KEY_N{ACT_LOW}};
  localparam int               DBW     = $clog2(DB_CYCLES + 1);

  // Synchroniser loads the idle pin level on reset so no press is seen.
  logic [KEY_N-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= INACT;
    end else begin
      sync_q[0] <= kif.key_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  logic [KEY_N-1:0] norm;
  assign norm = sync_q[SYNC_STAGES-1] ^ INACT;

  logic [DBW-1:0]   db_cnt_q [KEY_N];
  logic [DBW-1:0]   db_cnt_d [KEY_N];
  logic [KEY_N-1:0] keys_q, keys_d;
  logic [KEY_N-1:0] press_q, press_d;
  logic [KEY_N-1:0] release_q, release_d;

  always_comb begin
    keys_d    = keys_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < KEY_N; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (norm[i] == keys_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
        keys_d[i]    = norm[i];
        press_d[i]   = norm[i];
        release_d[i] = ~norm[i];
        db_cnt_d[i]  = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < KEY_N; i++) db_cnt_q[i] <= '0;
      keys_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < KEY_N; i++) db_cnt_q[i] <= db_cnt_d[i];
      keys_q    <= keys_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  logic [KEY_N-1:0] repeat_q;

  if (REPEAT_EN != 0) begin : g_rpt
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0]    rpt_cnt_q [KEY_N];
    logic [RW-1:0]    rpt_cnt_d [KEY_N];
    logic [KEY_N-1:0] first_q, first_d;
    logic [KEY_N-1:0] repeat_d;

    // Counter restarts on every hit, so it can never wrap into a false first repeat.
    always_comb begin
      first_d  = first_q;
      repeat_d = '0;
      for (int i = 0; i < KEY_N; i++) begin
        rpt_cnt_d[i] = rpt_cnt_q[i];
        if (!keys_q[i] || !keys_d[i]) begin
          rpt_cnt_d[i] = '0;
          first_d[i]   = 1'b1;
        end else if ((rpt_cnt_q[i] + 1'b1) ==
                     (first_q[i] ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD))) begin
          repeat_d[i]  = 1'b1;
          rpt_cnt_d[i] = '0;
          first_d[i]   = 1'b0;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int i = 0; i < KEY_N; i++) rpt_cnt_q[i] <= '0;
        first_q  <= '1;
        repeat_q <= '0;
      end else begin
        for (int i = 0; i < KEY_N; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
        first_q  <= first_d;
        repeat_q <= repeat_d;
      end
    end
  end else begin : g_no_rpt
    assign repeat_q = '0;
  end

  assign kif.keys        = keys_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;
  assign kif.key_repeat  = repeat_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: latency, glitch rejection, auto-repeat,
// simultaneous presses and reset mid-debounce.
module tb_key_conditioner;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  key_conditioner_if #(.KEY_N(4)) kif ();

  key_conditioner #(
    .KEY_N(4), .SYNC_STAGES(2), .KEY_ACTIVE_LOW(1), .DB_CYCLES(8),
    .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .kif   (kif)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] all_out();
    return {kif.keys, kif.key_press, kif.key_release, kif.key_repeat};
  endfunction

  initial begin
    logic [31:0] exp_rep;

    // 1: reset with all pins idle-high, then idle
    kif.key_raw = 4'hF;
    resetn = 1'b0;
    #23;
    check("reset_outs", {16'h0, all_out()}, 32'h0);
    resetn = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      check("idle_outs", {16'h0, all_out()}, 32'h0);
    end

    // 2: key 0 press and release latency
    kif.key_raw = 4'hE;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t2_press", {kif.keys[0], kif.key_press[0]}, (k < 10) ? 32'h0 : 32'h3);
    end
    tick();
    check("t2_press_1cyc", {kif.keys, kif.key_press}, 32'h10);
    kif.key_raw = 4'hF;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t2_release", {kif.keys[0], kif.key_release[0]}, (k < 10) ? 32'h2 : 32'h1);
    end
    tick();
    check("t2_release_1cyc", {kif.keys, kif.key_release}, 32'h0);

    // 3: 7-cycle glitch on key 1 then stable low
    kif.key_raw = 4'hD;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("t3_glitch", {kif.keys, kif.key_press}, 32'h0);
    end
    kif.key_raw = 4'hF;
    tick();
    check("t3_gap", {kif.keys, kif.key_press}, 32'h0);
    kif.key_raw = 4'hD;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t3_press", {kif.keys, kif.key_press}, (k < 10) ? 32'h0 : 32'h22);
    end
    tick();
    check("t3_single_press", {kif.keys, kif.key_press}, 32'h20);
    kif.key_raw = 4'hF;
    for (int k = 0; k < 12; k++) tick();
    check("t3_released", {28'h0, kif.keys}, 32'h0);

    // 4: auto-repeat on key 2, release suppresses further repeats
    kif.key_raw = 4'hB;
    for (int k = 1; k <= 10; k++) tick();
    check("t4_press", {kif.keys, kif.key_press}, 32'h44);
    exp_q = '{32'd20, 32'd25, 32'd30, 32'd35};
    for (int off = 1; off <= 60; off++) begin
      if (off == 31) kif.key_raw = 4'hF;
      tick();
      exp_rep = 32'h0;
      if (exp_q.size() > 0 && exp_q[0] == off) begin
        exp_rep = 32'h4;
        void'(exp_q.pop_front());
      end
      check("t4_repeat", {28'h0, kif.key_repeat}, exp_rep);
      check("t4_release", {28'h0, kif.key_release}, (off == 40) ? 32'h4 : 32'h0);
    end
    check("t4_queue_empty", exp_q.size(), 32'h0);

    kif.key_raw = 4'hB;
    for (int k = 1; k <= 10; k++) tick();
    check("t4_repress", {kif.keys, kif.key_press}, 32'h44);
    exp_q = '{32'd20, 32'd25};
    for (int off = 1; off <= 40; off++) begin
      if (off == 21) kif.key_raw = 4'hF;
      tick();
      exp_rep = 32'h0;
      if (exp_q.size() > 0 && exp_q[0] == off) begin
        exp_rep = 32'h4;
        void'(exp_q.pop_front());
      end
      check("t4_repeat2", {28'h0, kif.key_repeat}, exp_rep);
    end
    check("t4_released", {28'h0, kif.keys}, 32'h0);

    // 5: two keys pressed on the same edge
    kif.key_raw = 4'h6;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t5_press", {kif.keys, kif.key_press}, (k < 10) ? 32'h0 : 32'h99);
    end
    kif.key_raw = 4'hF;
    for (int k = 1; k <= 10; k++) tick();
    check("t5_release", {kif.keys, kif.key_release}, 32'h09);
    for (int k = 0; k < 5; k++) tick();

    // 6: reset while key 0 is held and key 1 is mid-debounce
    kif.key_raw = 4'hE;
    for (int k = 1; k <= 10; k++) tick();
    kif.key_raw = 4'hC;
    for (int k = 0; k < 7; k++) tick();
    check("t6_pre_reset", {28'h0, kif.keys}, 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_async_clear", {16'h0, all_out()}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_in_reset", {16'h0, all_out()}, 32'h0);
    resetn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t6_repress", {kif.keys, kif.key_press}, (k < 10) ? 32'h0 : 32'h33);
    end
    kif.key_raw = 4'hF;
    for (int k = 0; k < 12; k++) tick();
    check("t6_final", {28'h0, kif.keys}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
